// File: rtl/sdf_ntt_ctrl_gen_if.sv
// rtl/sdf_ntt_ctrl_gen_if.sv - control/status bundle between a frame source and the SDF NTT sequencer
interface sdf_ntt_ctrl_gen_if #(
  parameter int LOG_N = 4
);
  localparam int L  = LOG_N;
  localparam int TW = LOG_N - 1;

  logic                start;
  logic [1:0]          mode;
  logic                stall;
  logic                abort;
  logic                in_ready;
  logic [LOG_N-1:0]    in_addr;
  logic [L-1:0]        buf_sel;
  logic [L-1:0]        buf_en;
  logic [L*TW-1:0]     tw_idx;
  logic                intt_mode;
  logic [LOG_N-1:0]    out_addr;
  logic                data_valid;
  logic                done_tick;
  logic                busy;
  logic                mode_err;

  modport master (
    output start, mode, stall, abort,
    input  in_ready, in_addr, buf_sel, buf_en, tw_idx, intt_mode,
           out_addr, data_valid, done_tick, busy, mode_err
  );

  modport slave (
    input  start, mode, stall, abort,
    output in_ready, in_addr, buf_sel, buf_en, tw_idx, intt_mode,
           out_addr, data_valid, done_tick, busy, mode_err
  );
endinterface

// File: rtl/sdf_ntt_ctrl_gen.sv
// rtl/sdf_ntt_ctrl_gen.sv - frame sequencer for an N-point radix-2 SDF NTT/INTT pipeline
module sdf_ntt_ctrl_gen #(
  parameter int LOG_N    = 4,
  parameter int BFLY_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sdf_ntt_ctrl_gen_if.slave   ctl
);
  localparam int L    = LOG_N;
  localparam int N    = 1 << LOG_N;
  localparam int TW   = LOG_N - 1;
  localparam int T_L  = N - 1 + L * BFLY_LAT;
  localparam int LAST = T_L + N - 1;
  localparam int CW   = $clog2(LAST + 1);
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          intt_q;
  logic          mode_ok;

  assign mode_ok = (ctl.mode == 2'b10) || (ctl.mode == 2'b01);

  // Abort wins even while stalled; otherwise stall freezes every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      busy_q <= 1'b0;
      intt_q <= 1'b0;
    end else if (ctl.abort) begin
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (!ctl.stall) begin
      if (busy_q) begin
        if (cnt == LAST_C) begin
          cnt    <= '0;
          busy_q <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (ctl.start && mode_ok) begin
        cnt    <= '0;
        busy_q <= 1'b1;
        intt_q <= ctl.mode[0];
      end
    end
  end

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
    for (int i = 0; i < LOG_N; i++) bitrev[i] = x[LOG_N-1-i];
  endfunction

  logic                in_ready_d;
  logic [LOG_N-1:0]    in_addr_d;
  logic [L-1:0]        buf_sel_d;
  logic [L-1:0]        buf_en_d;
  logic [L*TW-1:0]     tw_idx_d;
  logic [LOG_N-1:0]    out_addr_d;
  logic                data_valid_d;
  logic                done_d;
  logic                run;

  // Stage s starts at T_s; ts accumulates D_s + BFLY_LAT as the loop walks the stages.
  always_comb begin
    int c;
    int ls;
    int lo;
    int ts;
    c            = int'(cnt);
    ls           = 0;
    lo           = c - T_L;
    ts           = 0;
    run          = busy_q && !ctl.stall;
    in_ready_d   = 1'b0;
    in_addr_d    = '0;
    buf_sel_d    = '0;
    buf_en_d     = '0;
    tw_idx_d     = '0;
    out_addr_d   = '0;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    if (busy_q) begin
      if (c < N) begin
        in_ready_d = run;
        in_addr_d  = cnt[LOG_N-1:0];
      end
      for (int s = 0; s < L; s++) begin
        ls = c - ts;
        if (ls >= 0 && ls < 2 * N) begin
          buf_en_d[s]  = run;
          buf_sel_d[s] = ls[LOG_N-1-s];
          if (ls[LOG_N-1-s])
            tw_idx_d[s*TW +: TW] = TW'((ls & ((N >> (s + 1)) - 1)) << s);
        end
        ts = ts + (N >> (s + 1)) + BFLY_LAT;
      end
      if (lo >= 0 && lo < N) begin
        data_valid_d = run;
        out_addr_d   = bitrev(lo[LOG_N-1:0]);
      end
      done_d = run && !ctl.abort && (cnt == LAST_C);
    end
  end

  assign ctl.in_ready   = in_ready_d;
  assign ctl.in_addr    = in_addr_d;
  assign ctl.buf_sel    = buf_sel_d;
  assign ctl.buf_en     = buf_en_d;
  assign ctl.tw_idx     = tw_idx_d;
  assign ctl.intt_mode  = intt_q;
  assign ctl.out_addr   = out_addr_d;
  assign ctl.data_valid = data_valid_d;
  assign ctl.done_tick  = done_d;
  assign ctl.busy       = busy_q;
  assign ctl.mode_err   = !busy_q && ctl.start && !mode_ok && !ctl.abort && !ctl.stall;
endmodule
